// File: rtl/fb_pkg.sv
// Shared constants for the frame-buffer fill engine: geometry defaults,
// register map, CTRL/STATUS bit positions and the FSM state type.
package fb_pkg;

  localparam int FB_W_DEF = 320;
  localparam int FB_H_DEF = 240;

  localparam logic [2:0] REG_X0     = 3'd0;
  localparam logic [2:0] REG_Y0     = 3'd1;
  localparam logic [2:0] REG_W      = 3'd2;
  localparam logic [2:0] REG_H      = 3'd3;
  localparam logic [2:0] REG_COLOR  = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_IE    = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_rect_walker.sv
// Walks a rectangle row by row (x fastest) and presents the linear
// frame-buffer address of the current pixel plus a last-pixel flag.
module fb_rect_walker
  import fb_pkg::*;
#(
  parameter int FB_W   = FB_W_DEF,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [9:0]        i_x0,
  input  logic [8:0]        i_y0,
  input  logic [9:0]        i_w,
  input  logic [8:0]        i_h,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [9:0] r_x;
  logic [9:0] r_xStart;
  logic [9:0] r_xEnd;
  logic [8:0] r_y;
  logic [8:0] r_yEnd;

  // End coordinates are captured at load so the rectangle is frozen for the fill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_xStart <= '0;
      r_xEnd   <= '0;
      r_y      <= '0;
      r_yEnd   <= '0;
    end else if (i_load) begin
      r_x      <= i_x0;
      r_xStart <= i_x0;
      r_xEnd   <= i_x0 + i_w - 10'd1;
      r_y      <= i_y0;
      r_yEnd   <= i_y0 + i_h - 9'd1;
    end else if (i_advance) begin
      if (r_x == r_xEnd) begin
        r_x <= r_xStart;
        r_y <= r_y + 9'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  assign o_last = (r_x == r_xEnd) && (r_y == r_yEnd);
  assign o_addr = ADDR_W'(r_y) * ADDR_W'(FB_W) + ADDR_W'(r_x);

endmodule

// File: rtl/fb_fill_arbiter.sv
// Rectangle fill engine sharing one frame-buffer write port with a CPU,
// using round-robin arbitration while a fill is running.
module fb_fill_arbiter
  import fb_pkg::*;
#(
  parameter int FB_W   = FB_W_DEF,
  parameter int FB_H   = FB_H_DEF,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [23:0]       cpu_wdata,
  output logic              cpu_ready,
  input  logic              cfg_wen,
  input  logic [2:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              fb_wen,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [23:0]       fb_wdata,
  output logic              irq
);

  fb_state_t         r_state;
  logic [9:0]        r_x0;
  logic [8:0]        r_y0;
  logic [9:0]        r_w;
  logic [8:0]        r_h;
  logic [23:0]       r_color;
  logic              r_ie;
  logic              r_done;
  logic              r_err;
  logic              r_cpuFirst;
  logic              r_fbWen;
  logic [ADDR_W-1:0] r_fbWaddr;
  logic [23:0]       r_fbWdata;

  logic              w_ctrlWr;
  logic              w_statusWr;
  logic              w_start;
  logic              w_abort;
  logic              w_rectOk;
  logic              w_fillReq;
  logic              w_cpuGrant;
  logic              w_fillGrant;
  logic              w_lastPix;
  logic [ADDR_W-1:0] w_pixAddr;
  logic              w_unusedWdata;

  assign w_ctrlWr      = cfg_wen && (cfg_addr == REG_CTRL);
  assign w_statusWr    = cfg_wen && (cfg_addr == REG_STATUS);
  assign w_start       = w_ctrlWr && cfg_wdata[CTRL_START] && (r_state == ST_IDLE);
  assign w_abort       = w_ctrlWr && cfg_wdata[CTRL_ABORT] && (r_state == ST_FILL);
  assign w_rectOk      = (r_w != '0) && (r_h != '0) &&
                         (({1'b0, r_x0} + {1'b0, r_w}) <= 11'(FB_W)) &&
                         (({1'b0, r_y0} + {1'b0, r_h}) <= 10'(FB_H));
  assign w_unusedWdata = ^cfg_wdata[31:24];

  // CPU wins when alone or when the fill took the previous contended slot
  assign w_fillReq   = (r_state == ST_FILL);
  assign w_cpuGrant  = cpu_wen && (!w_fillReq || r_cpuFirst);
  assign w_fillGrant = w_fillReq && !w_cpuGrant;
  assign cpu_ready   = w_cpuGrant;

  fb_rect_walker #(
    .FB_W   (FB_W),
    .ADDR_W (ADDR_W)
  ) u_walker (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_start && w_rectOk),
    .i_x0      (r_x0),
    .i_y0      (r_y0),
    .i_w       (r_w),
    .i_h       (r_h),
    .i_advance (w_fillGrant),
    .o_addr    (w_pixAddr),
    .o_last    (w_lastPix)
  );

  // Geometry and colour are frozen during a fill; ie stays writable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_ie    <= 1'b0;
    end else if (cfg_wen) begin
      if (r_state == ST_IDLE) begin
        case (cfg_addr)
          REG_X0:    r_x0    <= cfg_wdata[9:0];
          REG_Y0:    r_y0    <= cfg_wdata[8:0];
          REG_W:     r_w     <= cfg_wdata[9:0];
          REG_H:     r_h     <= cfg_wdata[8:0];
          REG_COLOR: r_color <= cfg_wdata[23:0];
          default:   ;
        endcase
      end
      if (cfg_addr == REG_CTRL) r_ie <= cfg_wdata[CTRL_IE];
    end
  end

  // A STATUS write clears the sticky flags, but a same-cycle completion still sets done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_statusWr) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (w_rectOk) r_state <= ST_FILL;
            else          r_err   <= 1'b1;
          end
        end
        ST_FILL: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (w_fillGrant && w_lastPix) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Priority only rotates on grants made while the fill is competing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpuFirst <= 1'b1;
      r_fbWen    <= 1'b0;
      r_fbWaddr  <= '0;
      r_fbWdata  <= '0;
    end else begin
      if (w_fillReq && w_cpuGrant) r_cpuFirst <= 1'b0;
      else if (w_fillGrant)        r_cpuFirst <= 1'b1;
      r_fbWen <= w_cpuGrant || w_fillGrant;
      if (w_cpuGrant) begin
        r_fbWaddr <= cpu_addr;
        r_fbWdata <= cpu_wdata;
      end else if (w_fillGrant) begin
        r_fbWaddr <= w_pixAddr;
        r_fbWdata <= r_color;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_X0:     cfg_rdata[9:0]  = r_x0;
      REG_Y0:     cfg_rdata[8:0]  = r_y0;
      REG_W:      cfg_rdata[9:0]  = r_w;
      REG_H:      cfg_rdata[8:0]  = r_h;
      REG_COLOR:  cfg_rdata[23:0] = r_color;
      REG_CTRL:   cfg_rdata[CTRL_IE] = r_ie;
      REG_STATUS: begin
        cfg_rdata[STAT_BUSY] = (r_state == ST_FILL);
        cfg_rdata[STAT_DONE] = r_done;
        cfg_rdata[STAT_ERR]  = r_err;
      end
      default: ;
    endcase
  end

  assign fb_wen   = r_fbWen;
  assign fb_waddr = r_fbWaddr;
  assign fb_wdata = r_fbWdata;
  assign irq      = r_done && r_ie;

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Randomised and directed checks of fb_fill_arbiter against a queue-based
// model of the fill rectangle, register file and round-robin arbitration.
module tb_fb_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wen;
  logic [16:0] cpu_addr;
  logic [23:0] cpu_wdata;
  logic        cpu_ready;
  logic        cfg_wen;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        fb_wen;
  logic [16:0] fb_waddr;
  logic [23:0] fb_wdata;
  logic        irq;

  fb_fill_arbiter #(
    .FB_W   (320),
    .FB_H   (240),
    .ADDR_W (17)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cfg_wen   (cfg_wen),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .fb_wen    (fb_wen),
    .fb_waddr  (fb_waddr),
    .fb_wdata  (fb_wdata),
    .irq       (irq)
  );

  always #10 clk = ~clk;

  int nTests = 0;
  int nFails = 0;
  int cycleNo = 0;

  // Model state: register shadows plus the list of pixels still to write
  int          mX0, mY0, mW, mH;
  logic [23:0] mColor;
  logic        mIe, mDone, mErr, mActive, mCpuFirst;
  int          fillQ[$];
  int          logAddr[$];
  int          logCyc[$];

  int          cpuMode;
  logic        curCw;
  logic [16:0] curCa;
  logic [23:0] curCd;
  logic        lastCpuGrant;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] modelReg(input int a);
    case (a)
      0: return 32'(mX0);
      1: return 32'(mY0);
      2: return 32'(mW);
      3: return 32'(mH);
      4: return {8'h0, mColor};
      5: return {29'h0, mIe, 2'b00};
      6: return {29'h0, mErr, mDone, mActive};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    mX0 = 0; mY0 = 0; mW = 0; mH = 0; mColor = '0;
    mIe = 0; mDone = 0; mErr = 0; mActive = 0; mCpuFirst = 1;
    fillQ.delete();
    curCw = 0; lastCpuGrant = 0;
  endtask

  // One clock cycle: drive at negedge, check ready, then check the registered write
  task automatic applyStimulus(input logic cw, input logic [16:0] ca, input logic [23:0] cd,
                               input logic gw, input logic [2:0] ga, input logic [31:0] gd);
    logic        fillReq, cpuG, fillG, wasActive;
    logic [16:0] expAddr;
    logic [23:0] expData;
    cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
    cfg_wen = gw; cfg_addr = ga; cfg_wdata = gd;
    #1;
    fillReq = mActive && (fillQ.size() > 0);
    cpuG    = cw && (!fillReq || mCpuFirst);
    fillG   = fillReq && !cpuG;
    expAddr = ca;
    expData = cd;
    if (fillG) begin
      expAddr = 17'(fillQ[0]);
      expData = mColor;
    end
    checkOutput("cpu_ready", {31'h0, cpu_ready}, {31'h0, cpuG});
    @(posedge clk);
    #1;
    cycleNo++;
    wasActive = mActive;
    if (wasActive && cpuG) mCpuFirst = 0;
    else if (fillG)        mCpuFirst = 1;
    if (fillG) void'(fillQ.pop_front());
    if (gw && ga == 3'd6) begin mDone = 0; mErr = 0; end
    if (gw && ga == 3'd5) mIe = gd[2];
    if (wasActive) begin
      if (gw && ga == 3'd5 && gd[1]) begin
        mActive = 0;
        fillQ.delete();
      end else if (fillG && fillQ.size() == 0) begin
        mActive = 0;
        mDone = 1;
      end
    end else begin
      if (gw && ga == 3'd5 && gd[0]) begin
        if (mW != 0 && mH != 0 && mX0 + mW <= 320 && mY0 + mH <= 240) begin
          for (int y = mY0; y < mY0 + mH; y++)
            for (int x = mX0; x < mX0 + mW; x++)
              fillQ.push_back(y * 320 + x);
          mActive = 1;
        end else begin
          mErr = 1;
        end
      end
      if (gw) begin
        case (ga)
          3'd0: mX0 = int'(gd[9:0]);
          3'd1: mY0 = int'(gd[8:0]);
          3'd2: mW = int'(gd[9:0]);
          3'd3: mH = int'(gd[8:0]);
          3'd4: mColor = gd[23:0];
          default: ;
        endcase
      end
    end
    checkOutput("fb_wen", {31'h0, fb_wen}, {31'h0, cpuG | fillG});
    if (cpuG || fillG) begin
      checkOutput("fb_waddr", {15'h0, fb_waddr}, {15'h0, expAddr});
      checkOutput("fb_wdata", {8'h0, fb_wdata}, {8'h0, expData});
    end
    if (fb_wen) begin
      logAddr.push_back(int'(fb_waddr));
      logCyc.push_back(cycleNo);
    end
    lastCpuGrant = cpuG;
    @(negedge clk);
  endtask

  task automatic step(input logic gw, input logic [2:0] ga, input logic [31:0] gd);
    if (!(curCw && !lastCpuGrant)) begin
      case (cpuMode)
        0: curCw = 0;
        1: begin curCw = 1; curCa = '0; curCd = 24'h00FF00; end
        default: begin
          curCw = ($urandom_range(0, 1) == 1);
          curCa = 17'($urandom_range(0, 76799));
          curCd = 24'($urandom);
        end
      endcase
    end
    applyStimulus(curCw, curCa, curCd, gw, ga, gd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd6, 32'h0);
  endtask

  task automatic setRect(input int x0, input int y0, input int w, input int h, input logic [23:0] c);
    step(1'b1, 3'd0, 32'(x0));
    step(1'b1, 3'd1, 32'(y0));
    step(1'b1, 3'd2, 32'(w));
    step(1'b1, 3'd3, 32'(h));
    step(1'b1, 3'd4, {8'h0, c});
  endtask

  task automatic checkAllRegs(input string tag);
    for (int a = 0; a < 8; a++) begin
      cfg_wen = 1'b0;
      cfg_addr = 3'(a);
      #1;
      checkOutput($sformatf("%s_reg%0d", tag, a), cfg_rdata, modelReg(a));
    end
    checkOutput({tag, "_irq"}, {31'h0, irq}, {31'h0, mDone & mIe});
  endtask

  task automatic doReset();
    rst = 1'b1; cpu_wen = 1'b0; cfg_wen = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cfg_addr = '0; cfg_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int expA[6];
    int n, guard, busyCycles;
    logic busy;
    cpuMode = 0;
    @(negedge clk);
    doReset();
    checkOutput("rst_fb_wen", {31'h0, fb_wen}, 32'h0);
    checkOutput("rst_fb_waddr", {15'h0, fb_waddr}, 32'h0);
    checkOutput("rst_fb_wdata", {8'h0, fb_wdata}, 32'h0);
    checkAllRegs("rst");

    // Basic 3x2 fill with no CPU traffic
    expA = '{1610, 1611, 1612, 1930, 1931, 1932};
    setRect(10, 5, 3, 2, 24'hFF0000);
    logAddr.delete(); logCyc.delete();
    step(1'b1, 3'd5, 32'h1);
    idle(8);
    checkOutput("basic_count", 32'(logAddr.size()), 32'd6);
    for (int i = 0; i < 6 && i < logAddr.size(); i++) begin
      checkOutput($sformatf("basic_addr%0d", i), 32'(logAddr[i]), 32'(expA[i]));
      checkOutput($sformatf("basic_cyc%0d", i), 32'(logCyc[i] - logCyc[0]), 32'(i));
    end
    checkAllRegs("basic");
    checkOutput("basic_status", modelReg(6), 32'h2);

    // Same fill contending with a CPU that never lets go
    doReset();
    cpuMode = 1;
    setRect(10, 5, 3, 2, 24'hFF0000);
    logAddr.delete();
    step(1'b1, 3'd5, 32'h1);
    cfg_addr = 3'd6;
    #1;
    busy = cfg_rdata[0];
    busyCycles = 0;
    while (busy && busyCycles < 40) begin
      step(1'b0, 3'd6, 32'h0);
      busyCycles++;
      busy = cfg_rdata[0];
    end
    checkOutput("contend_cycles", 32'(busyCycles), 32'd12);
    n = 0;
    foreach (logAddr[i]) if (logAddr[i] != 0) n++;
    checkOutput("contend_fill_writes", 32'(n), 32'd6);
    cpuMode = 0;
    idle(2);

    // Rectangle overhanging the right edge
    doReset();
    setRect(318, 0, 3, 1, 24'h123456);
    logAddr.delete();
    step(1'b1, 3'd5, 32'h1);
    idle(4);
    checkOutput("err_status", modelReg(6), 32'h4);
    checkOutput("err_writes", 32'(logAddr.size()), 32'd0);
    checkAllRegs("err");

    // Full screen fill aborted after 100 writes
    doReset();
    setRect(0, 0, 320, 240, 24'h0000FF);
    logAddr.delete();
    step(1'b1, 3'd5, 32'h1);
    guard = 0;
    while (logAddr.size() < 100 && guard < 300) begin
      idle(1);
      guard++;
    end
    step(1'b1, 3'd5, 32'h2);
    idle(4);
    n = logAddr.size();
    checkOutput("abort_count_ok", {31'h0, (n == 100 || n == 101)}, 32'h1);
    checkOutput("abort_status", modelReg(6), 32'h0);
    checkAllRegs("abort");

    // Bottom-right 1x1 fill with interrupts enabled
    doReset();
    step(1'b1, 3'd5, 32'h4);
    setRect(319, 239, 1, 1, 24'hABCDEF);
    logAddr.delete();
    step(1'b1, 3'd5, 32'h5);
    idle(3);
    checkOutput("corner_count", 32'(logAddr.size()), 32'd1);
    if (logAddr.size() > 0) checkOutput("corner_addr", 32'(logAddr[0]), 32'd76799);
    checkOutput("corner_irq", {31'h0, irq}, 32'h1);
    step(1'b1, 3'd6, 32'h0);
    checkOutput("corner_irq_clr", {31'h0, irq}, 32'h0);
    checkAllRegs("corner");

    // Randomised rectangles, CPU traffic and aborts
    doReset();
    cpuMode = 2;
    for (int it = 0; it < 10; it++) begin
      int w, h, x0, y0;
      if ($urandom_range(0, 4) != 0) begin
        w = $urandom_range(1, 8); h = $urandom_range(1, 4);
        x0 = $urandom_range(0, 320 - w); y0 = $urandom_range(0, 240 - h);
      end else begin
        w = $urandom_range(0, 8); h = $urandom_range(1, 4);
        x0 = $urandom_range(313, 1023); y0 = $urandom_range(0, 236);
      end
      setRect(x0, y0, w, h, 24'($urandom));
      step(1'b1, 3'd5, {29'h0, 1'($urandom_range(0, 1)), 2'b01});
      guard = 0;
      while (mActive && guard < 200) begin
        if ($urandom_range(0, 19) == 0) step(1'b1, 3'd5, 32'h2);
        else if ($urandom_range(0, 9) == 0) step(1'b1, 3'($urandom_range(0, 6)), $urandom);
        else idle(1);
        guard++;
      end
      checkOutput("rand_finished", {31'h0, mActive}, 32'h0);
      checkAllRegs("rand");
      step(1'b1, 3'd6, 32'h0);
    end
    cpuMode = 0;
    idle(2);

    // Reset in the middle of a fill
    setRect(0, 0, 320, 240, 24'h00FFFF);
    step(1'b1, 3'd5, 32'h1);
    idle(10);
    rst = 1'b1; cpu_wen = 1'b0; cfg_wen = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_fb_wen0", {31'h0, fb_wen}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midrst_fb_wen1", {31'h0, fb_wen}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkAllRegs("midrst");
    idle(4);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
